// File: rtl/mux_rr_pkg.sv
// Shared definitions for the 4:1 round-robin packet multiplexer slice.
package mux_rr_pkg;

    localparam int CH_NUM   = 4;
    localparam int SEL_BITS = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic [CH_NUM-1:0] onehot(input logic [SEL_BITS-1:0] idx);
        logic [CH_NUM-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter; ptr names the highest-priority requester.
module rr_arbiter_4
    import mux_rr_pkg::*;
(
    input  logic [CH_NUM-1:0]   req,
    input  logic [SEL_BITS-1:0] ptr,
    output logic [CH_NUM-1:0]   gnt_onehot,
    output logic [SEL_BITS-1:0] gnt_idx,
    output logic                any
);

    logic [SEL_BITS-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            cand = ptr + SEL_BITS'(k);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_onehot = any ? onehot(gnt_idx) : '0;
    end

endmodule

// File: rtl/mux_4_1_rr.sv
// Four-stream to one packet merger with round-robin arbitration, packet locking
// and a registered output stage tagged with the source channel index.
module mux_4_1_rr
    import mux_rr_pkg::*;
#(
    parameter int BITS_NUM = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [BITS_NUM-1:0] X0,
    input  logic [BITS_NUM-1:0] X1,
    input  logic [BITS_NUM-1:0] X2,
    input  logic [BITS_NUM-1:0] X3,
    input  logic [3:0]          X_VALID,
    input  logic [3:0]          X_LAST,
    output logic [3:0]          X_READY,
    output logic [BITS_NUM-1:0] Y,
    output logic [1:0]          Y_SEL,
    output logic                Y_LAST,
    output logic                Y_VALID,
    input  logic                Y_READY
);

    state_e                state_q, state_d;
    logic [SEL_BITS-1:0]   ptr_q, ptr_d;
    logic [SEL_BITS-1:0]   lidx_q, lidx_d;
    logic [BITS_NUM-1:0]   y_q, y_d;
    logic [SEL_BITS-1:0]   y_sel_q, y_sel_d;
    logic                  y_last_q, y_last_d;
    logic                  y_valid_q, y_valid_d;

    logic [CH_NUM-1:0]     gnt_onehot;
    logic [SEL_BITS-1:0]   gnt_idx;
    logic                  gnt_any;
    logic                  load;
    logic                  serve;
    logic [SEL_BITS-1:0]   sel;
    logic [CH_NUM-1:0]     ready_vec;
    logic                  xfer;
    logic [BITS_NUM-1:0]   x_sel_data;

    rr_arbiter_4 u_arb (
        .req        (X_VALID),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            lidx_q    <= '0;
            y_q       <= '0;
            y_sel_q   <= '0;
            y_last_q  <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lidx_q    <= lidx_d;
            y_q       <= y_d;
            y_sel_q   <= y_sel_d;
            y_last_q  <= y_last_d;
            y_valid_q <= y_valid_d;
        end
    end

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    always_comb begin
        load      = ~y_valid_q | Y_READY;
        serve     = (state_q == LOCKED) | gnt_any;
        sel       = (state_q == LOCKED) ? lidx_q : gnt_idx;
        ready_vec = (state_q == LOCKED) ? onehot(lidx_q) : gnt_onehot;
        X_READY   = (RST_N && load && serve) ? ready_vec : '0;
        xfer      = |(X_VALID & X_READY);
        case (sel)
            2'd0:    x_sel_data = X0;
            2'd1:    x_sel_data = X1;
            2'd2:    x_sel_data = X2;
            default: x_sel_data = X3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lidx_d    = lidx_q;
        y_d       = y_q;
        y_sel_d   = y_sel_q;
        y_last_d  = y_last_q;
        y_valid_d = y_valid_q;
        if (xfer) begin
            y_d       = x_sel_data;
            y_sel_d   = sel;
            y_last_d  = X_LAST[sel];
            y_valid_d = 1'b1;
            if (X_LAST[sel]) begin
                ptr_d   = sel + 2'd1;
                state_d = ARB;
            end else begin
                lidx_d  = sel;
                state_d = LOCKED;
            end
        end else if (Y_READY) begin
            y_valid_d = 1'b0;
        end
    end

    assign Y       = y_q;
    assign Y_SEL   = y_sel_q;
    assign Y_LAST  = y_last_q;
    assign Y_VALID = y_valid_q;

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Randomized and directed bench for mux_4_1_rr against a queue-based packet model.
module tb_mux_4_1_rr;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] X0, X1, X2, X3;
    logic [3:0]   X_VALID, X_LAST, X_READY;
    logic [W-1:0] Y;
    logic [1:0]   Y_SEL;
    logic         Y_LAST, Y_VALID, Y_READY;

    always #5 CLK = ~CLK;

    mux_4_1_rr #(.BITS_NUM(W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3),
        .X_VALID(X_VALID), .X_LAST(X_LAST), .X_READY(X_READY),
        .Y(Y), .Y_SEL(Y_SEL), .Y_LAST(Y_LAST), .Y_VALID(Y_VALID),
        .Y_READY(Y_READY)
    );

    typedef struct packed { logic [W-1:0] d; logic l; } word_t;
    typedef struct packed { logic [1:0] s; logic [W-1:0] d; logic l; } out_t;

    int    n_vec = 0;
    int    n_err = 0;
    word_t chq[4][$];
    bit    pres[4];
    out_t  sbq[$];
    int    rate   = 100;
    int    yr_pct = 100;
    int    last_gnt;
    // model: packet lock owner (-1 = arbitrating) and priority pointer
    int    m_owner;
    int    m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        r = '0;
        if (!RST_N) return r;
        if (sbq.size() != 0 && !Y_READY) return r;
        if (m_owner >= 0) begin
            r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 0; k < 4; k++) begin
            if (X_VALID[(m_ptr + k) % 4]) begin
                r[(m_ptr + k) % 4] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        sbq.delete();
        for (int i = 0; i < 4; i++) begin
            chq[i].delete();
            pres[i] = 0;
        end
    endtask

    task automatic drive();
        logic [W-1:0] xd[4];
        for (int i = 0; i < 4; i++) begin
            if (!pres[i] && chq[i].size() > 0 && $urandom_range(99) < rate) pres[i] = 1;
            X_VALID[i] = pres[i];
            xd[i]      = pres[i] ? chq[i][0].d : W'($urandom);
            X_LAST[i]  = pres[i] ? chq[i][0].l : 1'($urandom);
        end
        X0 = xd[0]; X1 = xd[1]; X2 = xd[2]; X3 = xd[3];
        Y_READY = ($urandom_range(99) < yr_pct);
    endtask

    task automatic step();
        logic [3:0]   er;
        logic [3:0]   xv;
        logic [3:0]   xl;
        logic [W-1:0] xd[4];
        logic         yr;
        drive();
        #1;
        er = model_ready();
        check("x_ready", {28'd0, X_READY}, {28'd0, er});
        xv = X_VALID; xl = X_LAST; yr = Y_READY;
        xd[0] = X0; xd[1] = X1; xd[2] = X2; xd[3] = X3;
        @(posedge CLK);
        #1;
        last_gnt = -1;
        if (sbq.size() != 0 && yr) void'(sbq.pop_front());
        for (int c = 0; c < 4; c++) begin
            if (er[c] && xv[c]) begin
                last_gnt = c;
                sbq.push_back('{s: 2'(c), d: xd[c], l: xl[c]});
                void'(chq[c].pop_front());
                pres[c] = 0;
                if (xl[c]) begin
                    m_ptr   = (c + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_owner = c;
                end
            end
        end
        check("y_valid", {31'd0, Y_VALID}, {31'd0, sbq.size() != 0});
        if (sbq.size() != 0) begin
            check("y_data", {24'd0, Y}, {24'd0, sbq[0].d});
            check("y_sel", {30'd0, Y_SEL}, {30'd0, sbq[0].s});
            check("y_last", {31'd0, Y_LAST}, {31'd0, sbq[0].l});
        end
    endtask

    task automatic push(input int ch, input logic [W-1:0] d, input logic l);
        chq[ch].push_back('{d: d, l: l});
    endtask

    // Asserts reset between edges, checks the asynchronous response, releases on a falling edge.
    task automatic pulse_reset();
        #2 RST_N = 1'b0;
        #1;
        check("rst_y_valid", {31'd0, Y_VALID}, 32'd0);
        check("rst_x_ready", {28'd0, X_READY}, 32'd0);
        check("rst_y", {24'd0, Y}, 32'd0);
        check("rst_y_sel", {30'd0, Y_SEL}, 32'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        logic [W-1:0] lk_d[4];
        logic [1:0]   lk_s[4];
        logic         lk_l[4];
        RST_N = 1'b0; X_VALID = '1; X_LAST = '0; Y_READY = 1'b1;
        X0 = '0; X1 = '0; X2 = '0; X3 = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("por_y_valid", {31'd0, Y_VALID}, 32'd0);
        check("por_x_ready", {28'd0, X_READY}, 32'd0);
        check("por_y_last", {31'd0, Y_LAST}, 32'd0);
        RST_N = 1'b1;

        // reset mid-packet, then a fresh single-word packet
        push(0, 8'h33, 1'b0);
        step();
        step();
        pulse_reset();
        push(0, 8'hAA, 1'b1);
        step();
        check("t1_y", {24'd0, Y}, 32'hAA);
        check("t1_sel", {30'd0, Y_SEL}, 32'd0);

        // round-robin fairness
        pulse_reset();
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < 4; c++) push(c, 8'h10 + 8'(c), 1'b1);
        for (int k = 0; k < 12; k++) begin
            step();
            check("t2_sel", {30'd0, Y_SEL}, 32'(k % 4));
            check("t2_valid", {31'd0, Y_VALID}, 32'd1);
        end

        // pointer wrap after a grant to channel 3
        pulse_reset();
        push(3, 8'h33, 1'b1);
        step();
        push(1, 8'h21, 1'b1);
        push(3, 8'h23, 1'b1);
        step();
        check("t3_first", {30'd0, Y_SEL}, 32'd1);
        step();
        check("t3_second", {30'd0, Y_SEL}, 32'd3);

        // packet lock on channel 2 while channel 0 waits
        pulse_reset();
        push(1, 8'h01, 1'b1);
        step();
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        push(0, 8'h55, 1'b1);
        lk_d = '{8'hC0, 8'hC1, 8'hC2, 8'h55};
        lk_s = '{2'd2, 2'd2, 2'd2, 2'd0};
        lk_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_y", {24'd0, Y}, {24'd0, lk_d[k]});
            check("t4_sel", {30'd0, Y_SEL}, {30'd0, lk_s[k]});
            check("t4_last", {31'd0, Y_LAST}, {31'd0, lk_l[k]});
        end

        // backpressure hold, then drain and load in the same cycle
        pulse_reset();
        for (int k = 0; k < 4; k++) push(2, 8'hB0 + 8'(k), 1'b1);
        yr_pct = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_hold_y", {24'd0, Y}, 32'hB0);
            check("t5_hold_v", {31'd0, Y_VALID}, 32'd1);
            check("t5_xready", {28'd0, X_READY}, 32'd0);
        end
        yr_pct = 100;
        step();
        check("t5_reload_y", {24'd0, Y}, 32'hB1);
        check("t5_reload_v", {31'd0, Y_VALID}, 32'd1);

        // idle: output drains, pointer is retained
        for (int c = 0; c < 4; c++) begin chq[c].delete(); pres[c] = 0; end
        step();
        check("t6_idle_v", {31'd0, Y_VALID}, 32'd0);
        step();
        for (int c = 0; c < 4; c++) push(c, 8'h60 + 8'(c), 1'b1);
        step();
        check("t6_ptr_gnt", 32'(last_gnt), 32'd3);

        // randomized traffic with occasional resets
        pulse_reset();
        rate = 60;
        yr_pct = 70;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < 4; c++)
                if (chq[c].size() < 4 && $urandom_range(3) == 0)
                    push(c, W'($urandom), ($urandom_range(2) == 0));
            if (n % 997 == 996) pulse_reset();
            if (n % 500 == 0) yr_pct = $urandom_range(20, 100);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
